// File: rtl/exec_pkg.sv
// exec_pkg: opcode, condition and flag types shared by the execute stage.
package exec_pkg;

    localparam int MUL_CYCLES = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
        C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
        C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
        C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/exec_stage_cond_check.sv
// cond_check: evaluates an ARM condition field against NZCV.
module cond_check
    import exec_pkg::*;
(
    input  logic [3:0] cond,
    input  nzcv_t      nzcv,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            C_EQ:    pass = nzcv.z;
            C_NE:    pass = !nzcv.z;
            C_CS:    pass = nzcv.c;
            C_CC:    pass = !nzcv.c;
            C_MI:    pass = nzcv.n;
            C_PL:    pass = !nzcv.n;
            C_VS:    pass = nzcv.v;
            C_VC:    pass = !nzcv.v;
            C_HI:    pass = nzcv.c && !nzcv.z;
            C_LS:    pass = !nzcv.c || nzcv.z;
            C_GE:    pass = (nzcv.n == nzcv.v);
            C_LT:    pass = (nzcv.n != nzcv.v);
            C_GT:    pass = !nzcv.z && (nzcv.n == nzcv.v);
            C_LE:    pass = nzcv.z || (nzcv.n != nzcv.v);
            C_AL:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// exec_stage: ARM data-processing execute stage with one output register.
// Define EXEC_STAGE_MUL_EN to add the 32-cycle shift-add multiplier.
module exec_stage
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cond,
    input  logic [3:0]  cmd,
    input  logic        s_bit,
    input  logic [31:0] rn,
    input  logic [31:0] shift_operand,
    input  logic        shifter_carry,
    input  logic        is_mul,
    input  logic [3:0]  rd_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [3:0]  flags,
    output logic        busy
);

    nzcv_t       flags_q;
    logic [31:0] result_q;
    logic        wr_en_q;
    logic [3:0]  wr_addr_q;
    logic        out_valid_q;

    logic        pass;
    logic        accept;
    logic        busy_w;
    logic        mul_start;
    logic        mul_fire;
    logic [31:0] mul_prod;
    logic [3:0]  mul_rd;
    logic        mul_s;

    cond_check u_cond (
        .cond (cond),
        .nzcv (flags_q),
        .pass (pass)
    );

    assign in_ready  = !reset && !busy_w && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign flags     = flags_q;
    assign busy      = busy_w;

    opcode_e     op;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic        arith;
    logic        alu_wr;
    logic [31:0] logic_res;
    logic [32:0] sum33;
    logic [31:0] alu_res;
    nzcv_t       alu_flags;

    assign op = opcode_e'(cmd);

    // Subtractions reuse the adder as a + ~b + cin, so C comes out as NOT borrow.
    always_comb begin
        add_a     = rn;
        add_b     = shift_operand;
        add_cin   = 1'b0;
        arith     = 1'b1;
        alu_wr    = 1'b1;
        logic_res = 32'h0;
        case (op)
            OP_AND: begin arith = 1'b0; logic_res = rn & shift_operand; end
            OP_EOR: begin arith = 1'b0; logic_res = rn ^ shift_operand; end
            OP_SUB: begin add_b = ~shift_operand; add_cin = 1'b1; end
            OP_RSB: begin add_a = shift_operand; add_b = ~rn; add_cin = 1'b1; end
            OP_ADD: ;
            OP_ADC: add_cin = flags_q.c;
            OP_SBC: begin add_b = ~shift_operand; add_cin = flags_q.c; end
            OP_RSC: begin
                add_a   = shift_operand;
                add_b   = ~rn;
                add_cin = flags_q.c;
            end
            OP_TST: begin
                arith = 1'b0; alu_wr = 1'b0; logic_res = rn & shift_operand;
            end
            OP_TEQ: begin
                arith = 1'b0; alu_wr = 1'b0; logic_res = rn ^ shift_operand;
            end
            OP_CMP: begin alu_wr = 1'b0; add_b = ~shift_operand; add_cin = 1'b1; end
            OP_CMN: alu_wr = 1'b0;
            OP_ORR: begin arith = 1'b0; logic_res = rn | shift_operand; end
            OP_MOV: begin arith = 1'b0; logic_res = shift_operand; end
            OP_BIC: begin arith = 1'b0; logic_res = rn & ~shift_operand; end
            OP_MVN: begin arith = 1'b0; logic_res = ~shift_operand; end
            default: ;
        endcase
    end

    assign sum33   = {1'b0, add_a} + {1'b0, add_b} + {32'h0, add_cin};
    assign alu_res = arith ? sum33[31:0] : logic_res;

    always_comb begin
        alu_flags.n = alu_res[31];
        alu_flags.z = (alu_res == 32'h0);
        alu_flags.c = arith ? sum33[32] : shifter_carry;
        alu_flags.v = arith
            ? ((add_a[31] == add_b[31]) && (sum33[31] != add_a[31]))
            : flags_q.v;
    end

`ifdef EXEC_STAGE_MUL_EN
    mul_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] acc_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic        ms_q;
    logic [3:0]  mrd_q;

    assign busy_w    = (state_q != S_IDLE);
    assign mul_start = accept && is_mul && pass;
    assign mul_fire  = (state_q == S_DONE) && (!out_valid_q || out_ready);
    assign mul_prod  = acc_q;
    assign mul_rd    = mrd_q;
    assign mul_s     = ms_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 32'h0;
            mcand_q  <= 32'h0;
            mplier_q <= 32'h0;
            ms_q     <= 1'b0;
            mrd_q    <= 4'h0;
        end else begin
            case (state_q)
                S_IDLE: if (mul_start) begin
                    state_q  <= S_MUL;
                    cnt_q    <= 5'd0;
                    acc_q    <= 32'h0;
                    mcand_q  <= rn;
                    mplier_q <= shift_operand;
                    ms_q     <= s_bit;
                    mrd_q    <= rd_addr;
                end
                S_MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'(MUL_CYCLES - 1)) state_q <= S_DONE;
                end
                S_DONE: if (!out_valid_q || out_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    logic unused_is_mul;
    assign unused_is_mul = is_mul;
    assign busy_w    = 1'b0;
    assign mul_start = 1'b0;
    assign mul_fire  = 1'b0;
    assign mul_prod  = 32'h0;
    assign mul_rd    = 4'h0;
    assign mul_s     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q     <= '0;
            result_q    <= 32'h0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 4'h0;
            out_valid_q <= 1'b0;
        end else if (mul_fire) begin
            result_q    <= mul_prod;
            wr_en_q     <= 1'b1;
            wr_addr_q   <= mul_rd;
            out_valid_q <= 1'b1;
            if (mul_s) begin
                flags_q.n <= mul_prod[31];
                flags_q.z <= (mul_prod == 32'h0);
            end
        end else if (accept) begin
            if (mul_start) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
                wr_en_q     <= pass && alu_wr;
                wr_addr_q   <= rd_addr;
                if (s_bit && pass) flags_q <= alu_flags;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed vectors for exec_stage with hand-computed results.
// Multiplier checks build only when EXEC_STAGE_MUL_EN is defined.
module tb_exec_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s_bit;
    logic [31:0] rn;
    logic [31:0] shift_operand;
    logic        shifter_carry;
    logic        is_mul;
    logic [3:0]  rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  flags;
    logic        busy;

    int n_cmp;
    int n_err;

    exec_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cond          (cond),
        .cmd           (cmd),
        .s_bit         (s_bit),
        .rn            (rn),
        .shift_operand (shift_operand),
        .shifter_carry (shifter_carry),
        .is_mul        (is_mul),
        .rd_addr       (rd_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .flags         (flags),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] op,
                         input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic sc,
                         input logic m, input logic [3:0] rd);
        cond          = c;
        cmd           = op;
        s_bit         = s;
        rn            = a;
        shift_operand = b;
        shifter_carry = sc;
        is_mul        = m;
        rd_addr       = rd;
        in_valid      = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [3:0]  op;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic        sc;
        logic [3:0]  rd;
        logic [31:0] res;
        logic        cr;
        logic        wr;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        int bad;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(4'hE, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
        in_valid = 1'b0;

        // c, op, s, rn, op2, shc, rd, result, check-result, wr_en, NZCV
        vecs.push_back(vec_t'{4'hE, 4'h4, 1, 32'h7FFFFFFF, 32'h1, 0, 4'h3, 32'h80000000, 1, 1, 4'b1001});
        vecs.push_back(vec_t'{4'hE, 4'hA, 1, 32'h5, 32'h5, 0, 4'h0, 32'h0, 1, 0, 4'b0110});
        vecs.push_back(vec_t'{4'h0, 4'h4, 0, 32'h1, 32'h2, 0, 4'h4, 32'h3, 1, 1, 4'b0110});
        vecs.push_back(vec_t'{4'hE, 4'h2, 1, 32'h1, 32'h2, 0, 4'h5, 32'hFFFFFFFF, 1, 1, 4'b1000});
        vecs.push_back(vec_t'{4'hE, 4'hD, 1, 32'h0, 32'h0, 1, 4'h6, 32'h0, 1, 1, 4'b0110});
        vecs.push_back(vec_t'{4'hE, 4'h5, 1, 32'h1, 32'h1, 0, 4'h7, 32'h3, 1, 1, 4'b0000});
        vecs.push_back(vec_t'{4'hE, 4'h4, 1, 32'h7FFFFFFF, 32'h1, 0, 4'h1, 32'h80000000, 1, 1, 4'b1001});
        vecs.push_back(vec_t'{4'hE, 4'hF, 1, 32'h0, 32'h0, 0, 4'h2, 32'hFFFFFFFF, 1, 1, 4'b1001});
        vecs.push_back(vec_t'{4'h0, 4'h4, 1, 32'h1, 32'h1, 0, 4'h8, 32'h0, 0, 0, 4'b1001});
        vecs.push_back(vec_t'{4'hF, 4'hD, 0, 32'h0, 32'h5, 0, 4'h9, 32'h0, 0, 0, 4'b1001});
        vecs.push_back(vec_t'{4'hB, 4'h4, 1, 32'h1, 32'h1, 0, 4'hA, 32'h0, 0, 0, 4'b1001});
        vecs.push_back(vec_t'{4'hA, 4'hC, 1, 32'hF0, 32'h0F, 1, 4'h9, 32'hFF, 1, 1, 4'b0011});
        vecs.push_back(vec_t'{4'h8, 4'h1, 1, 32'hFF, 32'h0F, 0, 4'hA, 32'hF0, 1, 1, 4'b0001});
        vecs.push_back(vec_t'{4'hE, 4'h3, 1, 32'h3, 32'h10, 0, 4'hB, 32'hD, 1, 1, 4'b0010});
        vecs.push_back(vec_t'{4'hE, 4'h6, 1, 32'h5, 32'h3, 0, 4'hC, 32'h2, 1, 1, 4'b0010});
        vecs.push_back(vec_t'{4'h3, 4'h8, 1, 32'hF0, 32'h0F, 0, 4'h0, 32'h0, 0, 0, 4'b0010});
        vecs.push_back(vec_t'{4'hE, 4'h8, 1, 32'hF0, 32'h0F, 0, 4'h0, 32'h0, 1, 0, 4'b0100});
        vecs.push_back(vec_t'{4'hE, 4'hE, 1, 32'hFF, 32'h0F, 1, 4'hD, 32'hF0, 1, 1, 4'b0010});
        vecs.push_back(vec_t'{4'hE, 4'hB, 1, 32'h1, 32'hFFFFFFFF, 0, 4'h0, 32'h0, 1, 0, 4'b0110});
        vecs.push_back(vec_t'{4'hE, 4'h9, 1, 32'h80000000, 32'h0, 0, 4'h0, 32'h80000000, 1, 0, 4'b1000});
        vecs.push_back(vec_t'{4'hE, 4'h7, 1, 32'h1, 32'h0, 0, 4'hE, 32'hFFFFFFFE, 1, 1, 4'b1000});
        vecs.push_back(vec_t'{4'hE, 4'h0, 0, 32'hF0F0, 32'hFF00, 0, 4'hF, 32'hF000, 1, 1, 4'b1000});

        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);

        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].c, vecs[i].op, vecs[i].s, vecs[i].a, vecs[i].b,
                  vecs[i].sc, 1'b0, vecs[i].rd);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'h1);
            if (vecs[i].cr)
                chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].wr));
            if (vecs[i].wr)
                chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].rd));
            chk($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].fl));
        end

        // Back-pressure: the held output must not be overwritten or lost.
        @(negedge clk);
        drive(4'hE, 4'h4, 1'b0, 32'd10, 32'd20, 1'b0, 1'b0, 4'h1);
        @(posedge clk); #1;
        chk("bp_first_result", result, 32'd30);
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'hE, 4'h4, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0, 4'h2);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_result", k), result, 32'd30);
            chk($sformatf("bp%0d_wr_addr", k), 32'(wr_addr), 32'h1);
            chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'h1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        chk("bp_second_result", result, 32'd3);
        chk("bp_second_wr_addr", 32'(wr_addr), 32'h2);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_out_valid", 32'(out_valid), 32'h0);

`ifdef EXEC_STAGE_MUL_EN
        @(negedge clk);
        drive(4'hE, 4'hA, 1'b1, 32'h5, 32'h5, 1'b0, 1'b0, 4'h0);
        @(posedge clk); #1;
        chk("premul_flags", 32'(flags), 32'h6);
        @(negedge clk);
        drive(4'hE, 4'hD, 1'b1, 32'hFFFFFFFF, 32'h2, 1'b0, 1'b1, 4'h5);
        @(posedge clk); #1;
        chk("mul_accept_busy", 32'(busy), 32'h1);
        chk("mul_accept_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        is_mul = 1'b0;
        lat = 0;
        bad = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid && (!busy || in_ready)) bad++;
        end
        // 33 edges after the accept edge, i.e. 34 cycles counting acceptance.
        chk("mul_latency", 32'(lat), 32'd33);
        chk("mul_busy_held", 32'(bad), 32'h0);
        chk("mul_result", result, 32'hFFFFFFFE);
        chk("mul_wr_en", 32'(wr_en), 32'h1);
        chk("mul_wr_addr", 32'(wr_addr), 32'h5);
        chk("mul_flags", 32'(flags), 32'hA);
        chk("mul_done_busy", 32'(busy), 32'h0);

        @(negedge clk);
        drive(4'hF, 4'hD, 1'b0, 32'h0, 32'h9, 1'b0, 1'b1, 4'h6);
        @(posedge clk); #1;
        chk("mulnv_out_valid", 32'(out_valid), 32'h1);
        chk("mulnv_wr_en", 32'(wr_en), 32'h0);
        chk("mulnv_busy", 32'(busy), 32'h0);

        @(negedge clk);
        drive(4'hE, 4'hD, 1'b1, 32'h3, 32'h4, 1'b0, 1'b1, 4'h7);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        is_mul = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mulrst_in_ready", 32'(in_ready), 32'h0);
        chk("mulrst_flags", 32'(flags), 32'h0);
        chk("mulrst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mulrst_ready_after", 32'(in_ready), 32'h1);
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("mulrst_no_output", 32'(bad), 32'h0);
`else
        @(negedge clk);
        drive(4'hE, 4'h4, 1'b0, 32'd6, 32'd7, 1'b0, 1'b1, 4'h3);
        @(posedge clk); #1;
        chk("nomul_result", result, 32'd13);
        chk("nomul_busy", 32'(busy), 32'h0);
        chk("nomul_out_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        is_mul = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  upstream operation present; in_ready  out  1  stage can accept.
REQ-004 SHALL have: cond  in  4  ARM condition field; cmd  in  4  ARM data-processing opcode; s_bit  in  1  update flags.
REQ-005 SHALL have: rn  in  32  first operand; shift_operand  in  32  second operand; shifter_carry  in  1  shifter carry-out.
REQ-006 SHALL have: is_mul  in  1  multiply request (MUL_EN only); rd_addr  in  4  destination register.
REQ-007 SHALL have: out_valid  out  1; out_ready  in  1; result  out  32; wr_en  out  1; wr_addr  out  4.
REQ-008 SHALL have: flags  out  4  current NZCV (N=bit3, V=bit0); busy  out  1  multiply in progress.

Function
REQ-009 SHALL accept an operation on any rising edge with in_valid and in_ready both high.
REQ-010 SHALL drive in_ready = !busy && (!out_valid || out_ready).
REQ-011 SHALL present the ALU result one cycle after acceptance in a single output register.
REQ-012 SHALL hold result, wr_en, wr_addr and out_valid stable while out_valid && !out_ready.
REQ-013 SHALL clear out_valid after a cycle with out_valid && out_ready and no new acceptance.
REQ-014 SHALL evaluate cond against the flags register value at the accept edge; cond 1110 always passes; cond 1111 always fails.
REQ-015 SHALL implement AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN per ARM ARM, operand2 = shift_operand.
REQ-016 SHALL compute arithmetic in 33 bits; C = bit 32 for ADD/ADC/CMN, C = NOT borrow for SUB/SBC/RSB/RSC/CMP.
REQ-017 SHALL set V on signed overflow for arithmetic ops and leave V unchanged for logical ops.
REQ-018 SHALL set C = shifter_carry for logical ops (AND EOR TST TEQ ORR MOV BIC MVN).
REQ-019 SHALL update NZCV at the accept edge only when s_bit=1 and the condition passes.
REQ-020 SHALL drive wr_en=0 for TST TEQ CMP CMN and for any failed condition; failed ops still produce out_valid.
REQ-021 SHALL use flags updated by operation k when evaluating operation k+1 accepted on the very next edge.

Reset
REQ-022 SHALL on reset force out_valid=0, result=0, wr_en=0, wr_addr=0, flags=0000, busy=0, FSM to IDLE.
REQ-023 SHALL on reset mid-multiply discard the partial product and produce no output.
REQ-024 SHALL drive in_ready=0 during the reset cycle.

Configuration
REQ-025 SHALL honour macro EXEC_STAGE_MUL_EN: defined -> iterative multiplier present; undefined -> is_mul ignored, busy tied 0.
REQ-026 SHALL with EXEC_STAGE_MUL_EN use FSM IDLE -> MUL (32 cycles, one shift-add per cycle) -> DONE -> IDLE.
REQ-027 SHALL enter MUL on acceptance with is_mul=1 and passing cond; failed-cond is_mul completes as a normal 1-cycle op.
REQ-028 SHALL hold busy=1 in MUL and DONE; DONE loads result (low 32 bits of rn*shift_operand) and asserts out_valid.
REQ-029 SHALL update only N and Z for a multiply with s_bit=1, at the DONE edge; C and V unchanged.
REQ-030 SHALL return DONE -> IDLE only when the output register is free (!out_valid || out_ready).

Structure
REQ-031 SHALL place opcode enum, condition enum, NZCV struct and MUL_CYCLES=32 in shared package exec_pkg.
REQ-032 SHALL instantiate one combinational sub-module cond_check (cond, NZCV -> pass).

Verification
REQ-033 SHALL cover: ADD s_bit=1 rn=7FFFFFFF op2=1 -> result 80000000, NZCV=1001, latency 1 cycle.
REQ-034 SHALL cover: CMP rn=5 op2=5 then BNE-style EQ ADD next cycle -> flags 0110, ADD passes, wr_en=1.
REQ-035 SHALL cover: MOVS op2=0 shifter_carry=1 -> result 0, NZCV=0110 (V retained 0), wr_en=1.
REQ-036 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held, no op lost.
REQ-037 SHALL cover (MUL_EN): MULS rn=FFFFFFFF op2=2 -> result FFFFFFFE after 34 cycles, N=1 Z=0, busy high throughout.
REQ-038 SHALL cover (MUL_EN): reset at cycle 10 of a multiply -> out_valid never rises, flags 0000, in_ready=1 next cycle.
